multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all ports are as follows:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- opcode  in  6  instruction opcode from the IR; valid from the cycle after ir_write
- mem_ready  in  1  memory handshake; the access completes in a cycle where the request and mem_ready are both 1
- pc_write  out  1  unconditional PC load
- branch  out  1  conditional PC load, qualified externally by ALU zero
- iord  out  1  memory address select: 0=PC, 1=ALU out
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load
- reg_dst  out  1  write register select: 0=rt, 1=rd
- mem_to_reg  out  1  write data select: 0=ALU out, 1=MDR
- reg_write  out  1  register file write
- alu_src_a  out  1  ALU A select: 0=PC, 1=rs
- alu_src_b  out  2  ALU B select: 00=rt, 01=const 4, 10=sign-ext imm, 11=imm<<2
- alu_op  out  2  00=add, 01=sub, 10=funct-decoded
- pc_src  out  2  00=ALU result, 01=ALU out register, 10=jump target
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode
- state  out  4  current state encoding, for debug

Function
REQ-002 The block SHALL be a Moore FSM with these state encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
REQ-003 Every output not listed for a state SHALL be 0 in that state.
REQ-004 FETCH SHALL drive mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
- ir_write and pc_write SHALL be 1 only in a cycle where mem_ready=1; the FSM then goes to DECODE.
- Otherwise the FSM SHALL stay in FETCH.
REQ-005 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00, latch opcode internally, and branch on it:
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000000 -> RTYPEEX
- 000100 -> BEQEX
- 000010 -> JEX
- 001000 -> ADDIEX (see REQ-017)
- any other opcode -> FETCH, with illegal_op=1 in that DECODE cycle
REQ-006 MEMADR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00, then go to MEMRD if the latched opcode is lw, else MEMWR.
REQ-007 MEMRD SHALL drive iord=1, mem_read=1 and hold until mem_ready=1, then go to MEMWB.
REQ-008 MEMWB SHALL drive reg_dst=0, mem_to_reg=1, reg_write=1, instr_done=1, then go to FETCH.
REQ-009 MEMWR SHALL drive iord=1, mem_write=1 and hold until mem_ready=1.
- In the mem_ready=1 cycle it SHALL drive instr_done=1 and go to FETCH.
REQ-010 RTYPEEX SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10, then go to RTYPEWB.
REQ-011 RTYPEWB SHALL drive reg_dst=1, reg_write=1, instr_done=1, then go to FETCH.
REQ-012 BEQEX SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, branch=1, instr_done=1, then go to FETCH.
REQ-013 JEX SHALL drive pc_src=10, pc_write=1, instr_done=1, then go to FETCH.
REQ-014 Latency with mem_ready tied to 1 SHALL be, counted in cycles from FETCH entry to the instr_done cycle inclusive:
- beq, j: 3
- R-type, sw, addi: 4
- lw: 5
- Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR SHALL add exactly one cycle.
REQ-015 opcode changes outside the DECODE cycle SHALL NOT affect state transitions, because the latched copy governs MEMADR.

Reset
REQ-016 Reset behaviour:
- While rst=1 at a rising clk edge, the next state SHALL be FETCH and the latched opcode SHALL clear to 0.
- While rst=1, mem_read, mem_write, reg_write, pc_write, branch, ir_write, instr_done and illegal_op SHALL be forced to 0 combinationally, in any state.
- After reset, all outputs SHALL take their FETCH values with strobes gated by mem_ready, and state=0.
- Reset asserted mid-instruction, including during an MEMRD/MEMWR wait, SHALL abandon the instruction without instr_done.

Configuration
REQ-017 The macro MULTICYCLE_ADDI_EN SHALL control addi support:
- Defined: opcode 001000 follows DECODE->ADDIEX->ADDIWB->FETCH.
  - ADDIEX drives alu_src_a=1, alu_src_b=10, alu_op=00.
  - ADDIWB drives reg_dst=0, mem_to_reg=0, reg_write=1, instr_done=1.
- Undefined: 001000 is illegal per REQ-005, and encodings 9 and 10 SHALL be unreachable.

Verification
REQ-018 The bench SHALL cover these directed scenarios:
- Reset, then mem_ready=1, opcode=000000: state sequence 0,1,6,7,0; reg_write=1 and reg_dst=1 only in state 7; instr_done pulses once.
- opcode=100011, mem_ready=0 for 2 cycles in MEMRD: sequence 0,1,2,3,3,3,4,0; instr_done in state 4; total 7 cycles.
- opcode=101011, mem_ready=1: mem_write=1 for exactly 1 cycle with iord=1; sequence 0,1,2,5,0.
- opcode=000100, then opcode=000010: branch=1 and pc_src=01 in state 8; pc_write=1 and pc_src=10 in state 11.
- opcode=111111: illegal_op=1 in state 1, next state 0, no instr_done. opcode=001000 yields states 9,10 when MULTICYCLE_ADDI_EN is defined, illegal_op otherwise.
- rst=1 asserted in MEMWR while mem_ready=0: mem_write=0 immediately; state=0 next cycle; no instr_done.

Source files
------------

// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control FSM: sequences datapath selects and strobes per instruction class.
// Latency: Moore outputs from the state register; FETCH/MEMWR strobes are additionally qualified by mem_ready.
// Backpressure: FETCH, MEMRD and MEMWR hold while mem_ready=0, each such cycle adds one cycle.
//
// Ports:
//   clk, rst             : rising-edge clock, synchronous active-high reset
//   opcode, mem_ready    : IR opcode (sampled in DECODE), memory handshake
//   pc_write .. illegal_op : datapath control outputs (see state table below)
//   state                : current state encoding for debug
//
// Build option: define MULTICYCLE_ADDI_EN to add addi (opcode 001000) through ADDIEX/ADDIWB;
// without it, 001000 decodes as illegal and encodings 9/10 are never entered.

module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       branch,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    state_e     state_q, state_d;
    logic [5:0] opcode_q;

    // Ungated strobes; reset masks them below regardless of state.
    logic pc_write_s, branch_s, mem_read_s, mem_write_s, ir_write_s;
    logic reg_write_s, instr_done_s, illegal_op_s;

    // opcode_q is the only copy MEMADR consults, so IR changes after DECODE are harmless.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            opcode_q <= 6'd0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                opcode_q <= opcode;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_write_s   = 1'b0;
        branch_s     = 1'b0;
        mem_read_s   = 1'b0;
        mem_write_s  = 1'b0;
        ir_write_s   = 1'b0;
        reg_write_s  = 1'b0;
        instr_done_s = 1'b0;
        illegal_op_s = 1'b0;
        iord         = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_RT;
        alu_op       = ALU_ADD;
        pc_src       = PCSRC_ALU;

        unique case (state_q)
            S_FETCH: begin
                // Request stays up while waiting; PC+4 and IR load only on the completing cycle.
                mem_read_s = 1'b1;
                alu_src_b  = SRCB_FOUR;
                ir_write_s = mem_ready;
                pc_write_s = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                // Branch target precomputed here so BEQEX can take it from the ALU out register.
                alu_src_b = SRCB_IMMSH;
                unique case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_J:         state_d = S_JEX;
`ifdef MULTICYCLE_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default: begin
                        state_d      = S_FETCH;
                        illegal_op_s = 1'b1;
                    end
                endcase
            end

            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = (opcode_q == OP_LW) ? S_MEMRD : S_MEMWR;
            end

            S_MEMRD: begin
                iord       = 1'b1;
                mem_read_s = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end

            S_MEMWB: begin
                mem_to_reg   = 1'b1;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
            end

            S_MEMWR: begin
                // The store finishes in the handshake cycle itself, so done is qualified by mem_ready.
                iord        = 1'b1;
                mem_write_s = 1'b1;
                if (mem_ready) begin
                    instr_done_s = 1'b1;
                    state_d      = S_FETCH;
                end
            end

            S_RTYPEEX: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_d   = S_RTYPEWB;
            end

            S_RTYPEWB: begin
                reg_dst      = 1'b1;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
            end

            S_BEQEX: begin
                // PC load is conditional on ALU zero outside this block.
                alu_src_a    = 1'b1;
                alu_op       = ALU_SUB;
                pc_src       = PCSRC_ALUOUT;
                branch_s     = 1'b1;
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
            end

`ifdef MULTICYCLE_ADDI_EN
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                state_d   = S_ADDIWB;
            end

            S_ADDIWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
            end
`endif

            S_JEX: begin
                pc_src       = PCSRC_JUMP;
                pc_write_s   = 1'b1;
                instr_done_s = 1'b1;
                state_d      = S_FETCH;
            end

            default: begin
                // Unused encodings (including 9/10 without addi) recover to FETCH.
                state_d = S_FETCH;
            end
        endcase
    end

    // Reset suppresses every side-effecting strobe immediately, so an abandoned
    // access or write-back cannot leak out during the reset cycle.
    assign pc_write   = pc_write_s   & ~rst;
    assign branch     = branch_s     & ~rst;
    assign mem_read   = mem_read_s   & ~rst;
    assign mem_write  = mem_write_s  & ~rst;
    assign ir_write   = ir_write_s   & ~rst;
    assign reg_write  = reg_write_s  & ~rst;
    assign instr_done = instr_done_s & ~rst;
    assign illegal_op = illegal_op_s & ~rst;
    assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: each step's expected state and output vector is queued, then drained cycle by cycle.
// Latency: inputs driven at the falling edge, DUT sampled 1 time unit later, state advances on the rising edge.
// Backpressure: mem_ready stalls are scripted per step in the queued stimulus.

module tb_multicycle_control;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, branch, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       instr_done, illegal_op;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;
    int done_cnt;

    typedef struct {
        logic [3:0] st;
        logic       mr;
        logic [5:0] op;
        logic       rs;
    } step_t;

    step_t sbq[$];

    multicycle_control dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .mem_ready  (mem_ready),
        .pc_write   (pc_write),
        .branch     (branch),
        .iord       (iord),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .instr_done (instr_done),
        .illegal_op (illegal_op),
        .state      (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic op_legal(input logic [5:0] op);
        logic ok;
        ok = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
             (op == 6'b000100) || (op == 6'b000010);
`ifdef MULTICYCLE_ADDI_EN
        ok = ok || (op == 6'b001000);
`endif
        return ok;
    endfunction

    // Output vector order: pw br iord mrd mwr irw rdst m2r rw sa sb[2] aop[2] psrc[2] done ill
    function automatic logic [17:0] exp_out(input logic [3:0] st, input logic mr,
                                            input logic [5:0] op, input logic rs);
        logic       pw, br, io, mrd, mwr, irw, rdst, m2r, rw, sa, dn, ill;
        logic [1:0] sb, aop, ps;
        {pw, br, io, mrd, mwr, irw, rdst, m2r, rw, sa, dn, ill} = 12'd0;
        sb = 2'b00; aop = 2'b00; ps = 2'b00;
        case (st)
            4'd0:  begin mrd = 1'b1; sb = 2'b01; irw = mr; pw = mr; end
            4'd1:  begin sb = 2'b11; ill = ~op_legal(op); end
            4'd2:  begin sa = 1'b1; sb = 2'b10; end
            4'd3:  begin io = 1'b1; mrd = 1'b1; end
            4'd4:  begin m2r = 1'b1; rw = 1'b1; dn = 1'b1; end
            4'd5:  begin io = 1'b1; mwr = 1'b1; dn = mr; end
            4'd6:  begin sa = 1'b1; aop = 2'b10; end
            4'd7:  begin rdst = 1'b1; rw = 1'b1; dn = 1'b1; end
            4'd8:  begin sa = 1'b1; aop = 2'b01; ps = 2'b01; br = 1'b1; dn = 1'b1; end
            4'd9:  begin sa = 1'b1; sb = 2'b10; end
            4'd10: begin rw = 1'b1; dn = 1'b1; end
            4'd11: begin ps = 2'b10; pw = 1'b1; dn = 1'b1; end
            default: ;
        endcase
        if (rs) begin
            {pw, br, mrd, mwr, irw, rw, dn, ill} = 8'd0;
        end
        return {pw, br, io, mrd, mwr, irw, rdst, m2r, rw, sa, sb, aop, ps, dn, ill};
    endfunction

    task automatic push(input logic [3:0] st, input logic mr, input logic [5:0] op, input logic rs);
        step_t e;
        e.st = st; e.mr = mr; e.op = op; e.rs = rs;
        sbq.push_back(e);
    endtask

    // Each queued step is one clock cycle; the queue length bounds the run.
    task automatic drain(input string tag);
        step_t       e;
        logic [17:0] obs, exp_v;
        int          cyc;
        cyc = 0;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            @(negedge clk);
            rst       = e.rs;
            mem_ready = e.mr;
            opcode    = e.op;
            #1;
            obs = {pc_write, branch, iord, mem_read, mem_write, ir_write, reg_dst,
                   mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src,
                   instr_done, illegal_op};
            exp_v = exp_out(e.st, e.mr, e.op, e.rs);
            if (instr_done === 1'b1) done_cnt++;
            checks++;
            assert (state === e.st) else begin
                errors++;
                $error("FAIL %s state cyc=%0d observed=%0d expected=%0d", tag, cyc, state, e.st);
            end
            checks++;
            assert (obs === exp_v) else begin
                errors++;
                $error("FAIL %s outputs cyc=%0d st=%0d observed=%b expected=%b", tag, cyc, e.st, obs, exp_v);
            end
            cyc++;
        end
    endtask

    task automatic check_done(input string tag, input int expected);
        checks++;
        assert (done_cnt === expected) else begin
            errors++;
            $error("FAIL %s instr_done_count observed=%0d expected=%0d", tag, done_cnt, expected);
        end
        done_cnt = 0;
    endtask

    initial begin
        rst       = 1'b1;
        mem_ready = 1'b0;
        opcode    = 6'b000000;
        done_cnt  = 0;

        // Reset: strobes masked even with mem_ready high in FETCH.
        push(4'd0, 1'b0, 6'b000000, 1'b1);
        push(4'd0, 1'b1, 6'b000000, 1'b1);
        drain("reset");
        check_done("reset", 0);

        // R-type: 0,1,6,7.
        push(4'd0, 1'b1, 6'b000000, 1'b0);
        push(4'd1, 1'b1, 6'b000000, 1'b0);
        push(4'd6, 1'b1, 6'b000000, 1'b0);
        push(4'd7, 1'b1, 6'b000000, 1'b0);
        drain("rtype");
        check_done("rtype", 1);

        // lw with two wait cycles in MEMRD; opcode scrambled after DECODE to exercise the latch.
        push(4'd0, 1'b1, 6'b100011, 1'b0);
        push(4'd1, 1'b1, 6'b100011, 1'b0);
        push(4'd2, 1'b1, 6'b101011, 1'b0);
        push(4'd3, 1'b0, 6'b111111, 1'b0);
        push(4'd3, 1'b0, 6'b000000, 1'b0);
        push(4'd3, 1'b1, 6'b000000, 1'b0);
        push(4'd4, 1'b1, 6'b000000, 1'b0);
        drain("lw");
        check_done("lw", 1);

        // sw: one-cycle write with iord=1.
        push(4'd0, 1'b1, 6'b101011, 1'b0);
        push(4'd1, 1'b1, 6'b101011, 1'b0);
        push(4'd2, 1'b1, 6'b100011, 1'b0);
        push(4'd5, 1'b1, 6'b100011, 1'b0);
        drain("sw");
        check_done("sw", 1);

        // beq with one FETCH stall, then j.
        push(4'd0, 1'b0, 6'b000100, 1'b0);
        push(4'd0, 1'b1, 6'b000100, 1'b0);
        push(4'd1, 1'b1, 6'b000100, 1'b0);
        push(4'd8, 1'b1, 6'b000100, 1'b0);
        push(4'd0, 1'b1, 6'b000010, 1'b0);
        push(4'd1, 1'b1, 6'b000010, 1'b0);
        push(4'd11, 1'b1, 6'b000010, 1'b0);
        drain("beq_j");
        check_done("beq_j", 2);

        // Illegal opcode: back to FETCH with no done.
        push(4'd0, 1'b1, 6'b111111, 1'b0);
        push(4'd1, 1'b1, 6'b111111, 1'b0);
        push(4'd0, 1'b0, 6'b111111, 1'b0);
        drain("illegal");
        check_done("illegal", 0);

        // addi: full path when enabled, illegal otherwise.
        push(4'd0, 1'b1, 6'b001000, 1'b0);
        push(4'd1, 1'b1, 6'b001000, 1'b0);
`ifdef MULTICYCLE_ADDI_EN
        push(4'd9, 1'b1, 6'b001000, 1'b0);
        push(4'd10, 1'b1, 6'b001000, 1'b0);
        drain("addi");
        check_done("addi", 1);
`else
        push(4'd0, 1'b0, 6'b001000, 1'b0);
        drain("addi");
        check_done("addi", 0);
`endif

        // Reset during a stalled store: write strobe drops at once, instruction abandoned,
        // then a beq runs normally afterwards.
        push(4'd0, 1'b1, 6'b101011, 1'b0);
        push(4'd1, 1'b1, 6'b101011, 1'b0);
        push(4'd2, 1'b1, 6'b101011, 1'b0);
        push(4'd5, 1'b0, 6'b101011, 1'b0);
        push(4'd5, 1'b0, 6'b101011, 1'b1);
        push(4'd0, 1'b1, 6'b000100, 1'b0);
        push(4'd1, 1'b1, 6'b000100, 1'b0);
        push(4'd8, 1'b1, 6'b000100, 1'b0);
        drain("rst_memwr");
        check_done("rst_memwr", 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
